// File: rtl/spike_event_fifo.sv
// spike_event_fifo: timestamps qualified spikes from the neuron and buffers
// them in a small circular FIFO, drained over a valid/ready handshake.
// A sticky overflow flag records any event dropped while the FIFO was full.
module spike_event_fifo #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    spike_in,
    input  logic                    out_ready,
    input  logic                    clear_overflow,
    output logic [TS_WIDTH-1:0]     out_data,
    output logic                    out_valid,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    // Handshake decode; a pop frees the head slot at the same edge, so a
    // push into a full FIFO is still accepted when a pop coincides.
    always_comb begin
        full     = (fifo_count == CW'(DEPTH));
        pop      = out_valid & out_ready;
        push_req = enable & spike_in;
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Outputs come straight from the count register and the array head,
    // so out_ready never reaches them combinationally.
    assign out_valid = (fifo_count != '0);
    assign out_data  = mem[rd_ptr];

    // Free-running timestamp, advanced only by the neuron update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else if (enable) begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    // Event storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= ts;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); occupancy tracked by count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo: scenario tasks drive stimulus; a negedge scoreboard
// queues each accepted timestamp and compares it when the DUT pops it.
module tb_spike_event_fifo;

    localparam int DEPTH = 8;
    localparam int TSW   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            spike_in = 1'b0;
    logic            out_ready = 1'b0;
    logic            clear_overflow = 1'b0;
    logic [TSW-1:0]  out_data;
    logic            out_valid;
    logic [3:0]      fifo_count;
    logic            overflow;

    int vectors = 0;
    int miscompares = 0;

    // reference model: expected contents, timestamp, sticky flag
    logic [TSW-1:0] sb [$];
    logic [TSW-1:0] m_ts = '0;
    logic           m_ovf = 1'b0;

    spike_event_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
        .out_ready(out_ready), .clear_overflow(clear_overflow),
        .out_data(out_data), .out_valid(out_valid),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: at each negedge compare outputs with the model, then
    // advance the model by what the coming posedge will do.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                vectors++;
                if (out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0 || out_data !== 8'd0) begin
                    miscompares++;
                    $display("FAIL reset_state: valid=%b count=%0d ovf=%b data=%0d, want all 0",
                             out_valid, fifo_count, overflow, out_data);
                end
                sb.delete();
                m_ts = '0;
                m_ovf = 1'b0;
            end else begin
                bit push, pop, full, drop;
                vectors++;
                if (int'(fifo_count) !== sb.size() || out_valid !== (sb.size() != 0) || overflow !== m_ovf) begin
                    miscompares++;
                    $display("FAIL sb_status: count=%0d valid=%b ovf=%b, want count=%0d valid=%b ovf=%b",
                             fifo_count, out_valid, overflow, sb.size(), sb.size() != 0, m_ovf);
                end
                if (sb.size() > 0) begin
                    vectors++;
                    if (out_data !== sb[0]) begin
                        miscompares++;
                        $display("FAIL sb_head: data=%0d, want %0d", out_data, sb[0]);
                    end
                end
                push = enable && spike_in;
                pop  = out_ready && (sb.size() > 0);
                full = (sb.size() == DEPTH);
                drop = push && full && !pop;
                if (pop) void'(sb.pop_front());
                if (push && !drop) sb.push_back(m_ts);
                if (drop) m_ovf = 1'b1;
                else if (clear_overflow) m_ovf = 1'b0;
                if (enable) m_ts = m_ts + 8'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // advance with enable=1 until the timestamp reaches target (bounded)
    task automatic run_to_ts(input logic [TSW-1:0] target);
        int n = 0;
        while (m_ts != target && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (m_ts != target) begin
            miscompares++;
            $display("FAIL ts_wait: ts=%0d, want %0d", m_ts, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: valid=%b count=%0d ovf=%b, want 0", out_valid, fifo_count, overflow);
        end
        rst_n = 1'b1;
        enable = 1'b1; out_ready = 1'b1;
        repeat (10) tick();
        vectors++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle: count=%0d valid=%b, want 0", fifo_count, out_valid);
        end
        // timestamp after 10 enables must be 10
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd10) begin
            miscompares++;
            $display("FAIL idle_ts: valid=%b data=%0d, want 1/10", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1; out_ready = 1'b1;
        run_to_ts(8'd3);
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd3) begin
            miscompares++;
            $display("FAIL single: valid=%b data=%0d, want 1/3", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
            miscompares++;
            $display("FAIL single_drain: valid=%b count=%0d, want 0/0", out_valid, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        logic [TSW-1:0] spikes [3] = '{8'd2, 8'd4, 8'd7};
        logic [TSW-1:0] want;
        do_reset();
        enable = 1'b1;
        foreach (spikes[i]) begin
            run_to_ts(spikes[i]);
            spike_in = 1'b1;
            tick();
            spike_in = 1'b0;
        end
        repeat (3) tick();
        vectors++;
        if (fifo_count !== 4'd3 || out_data !== 8'd2) begin
            miscompares++;
            $display("FAIL hold: count=%0d data=%0d, want 3/2", fifo_count, out_data);
        end
        out_ready = 1'b1;
        foreach (spikes[i]) begin
            want = spikes[i];
            vectors++;
            if (out_valid !== 1'b1 || out_data !== want) begin
                miscompares++;
                $display("FAIL order: valid=%b data=%0d, want 1/%0d", out_valid, out_data, want);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL order_end: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        enable = 1'b1; spike_in = 1'b1;
        repeat (10) tick();
        spike_in = 1'b0;
        vectors++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: count=%0d ovf=%b, want 8/1", fifo_count, overflow);
        end
        // drop and clear together: set wins
        spike_in = 1'b1; clear_overflow = 1'b1;
        tick();
        spike_in = 1'b0; clear_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins: ovf=%b, want 1", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain: data=%0d, want %0d", out_data, i);
            end
            tick();
        end
        out_ready = 1'b0;
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear: ovf=%b valid=%b, want 0/0", overflow, out_valid);
        end
    endtask

    task automatic test_full_pop_wrap();
        int n = 0;
        do_reset();
        enable = 1'b1; spike_in = 1'b1;
        repeat (DEPTH) tick();
        out_ready = 1'b1;
        tick();
        spike_in = 1'b0;
        vectors++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0 || out_data !== 8'd1) begin
            miscompares++;
            $display("FAIL full_pop: count=%0d ovf=%b data=%0d, want 8/0/1", fifo_count, overflow, out_data);
        end
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        run_to_ts(8'd255);
        spike_in = 1'b1;
        tick();
        vectors++;
        if (out_data !== 8'd255 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_255: valid=%b data=%0d, want 1/255", out_valid, out_data);
        end
        tick();
        spike_in = 1'b0;
        vectors++;
        if (out_data !== 8'd0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_0: valid=%b data=%0d, want 1/0", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1; spike_in = 1'b1;
        repeat (DEPTH + 1) tick();
        spike_in = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0; enable = 1'b0;
        vectors++;
        if (fifo_count !== 4'd5 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: count=%0d ovf=%b, want 5/1", fifo_count, overflow);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b count=%0d ovf=%b, want 0", out_valid, fifo_count, overflow);
        end
        rst_n = 1'b1;
        sb.delete(); m_ts = '0; m_ovf = 1'b0;
        tick();
        enable = 1'b1; spike_in = 1'b1;
        tick();
        enable = 1'b0; spike_in = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
            miscompares++;
            $display("FAIL post_reset: valid=%b data=%0d, want 1/0", out_valid, out_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spike_event_fifo.md
Name: spike_event_fifo

Overview:
- Downstream of the recurrent spiking neuron: consumes its spike_out and turns each spike into a timestamped event.
- Buffers events in a small FIFO and drains them to the chip output / host logic over a valid/ready handshake.
- Lets slow external readout capture bursts of spikes without loss, up to DEPTH events.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_WIDTH, 8, timestamp width in bits; also the event data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- enable  input  1  neuron update strobe; advances the timestamp and qualifies spike_in.
- spike_in  input  1  spike from the neuron's spike_out.
- out_ready  input  1  consumer ready for the head event.
- clear_overflow  input  1  synchronous clear of the sticky overflow flag.
- out_data  output  TS_WIDTH  timestamp of the head event.
- out_valid  output  1  head event is present.
- fifo_count  output  $clog2(DEPTH)+1  number of stored events, 0..DEPTH.
- overflow  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - timestamp counter = 0; read/write pointers = 0; fifo_count = 0.
  - out_valid = 0, out_data = 0, overflow = 0.
  - Reset asserted mid-operation discards all stored events immediately.
- Timestamp:
  - TS_WIDTH-bit counter, increments by 1 on each cycle with enable=1; holds otherwise.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Push request: enable=1 and spike_in=1 in the same cycle.
  - The pushed value is the timestamp before that cycle's increment, e.g. ts=5 with push stores 5 and ts becomes 6.
  - spike_in with enable=0 is ignored.
- Pop: occurs on a cycle where out_valid=1 and out_ready=1; the head entry is removed at that edge.
- Output timing:
  - out_data and out_valid come straight from registers/array head.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_data is undefined (not checked) when out_valid=0.
- Latency: a push into an empty FIFO gives out_valid=1 on the cycle after the push edge; there is no same-cycle bypass.
- Full (fifo_count=DEPTH):
  - A push without a simultaneous pop is dropped; overflow is set at that edge; stored data is unchanged.
  - A push with a simultaneous pop is accepted; count stays at DEPTH.
- Empty (fifo_count=0): out_valid=0; out_ready is ignored; pointers do not move.
- Simultaneous push and pop when not empty: both happen; count is unchanged.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty is derived from fifo_count.
- overflow:
  - Remains 1 until clear_overflow=1 is sampled.
  - If a drop and clear_overflow occur in the same cycle, set wins and overflow stays 1.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, enable=1 for 10 cycles, spike_in=0, out_ready=1 -> out_valid=0, fifo_count=0, overflow=0 throughout; internal ts=10.
- Single event: enable=1 always; spike_in=1 only in the cycle where ts=3; out_ready=1 -> one cycle later out_valid=1, out_data=3; next cycle out_valid=0, fifo_count=0.
- Backpressure/ordering: out_ready=0; spikes at ts 2,4,7 -> fifo_count=3, out_data holds 2. Then out_ready=1 -> events 2,4,7 in consecutive cycles, then out_valid=0.
- Overflow: out_ready=0; spike_in=1 with enable=1 for 10 cycles from ts=0 -> fifo_count=8, overflow=1, drained data 0..7. Assert clear_overflow for one cycle with no drop -> overflow=0.
- Full with simultaneous pop, plus wrap: fill to 8; next cycle push with out_ready=1 -> count stays 8, no overflow. Run ts past 255 with a spike at ts=255 and the next at ts=0 -> events 255 then 0.
- Reset mid-stream: 5 events stored, overflow=1; pulse rst_n low asynchronously between clock edges -> out_valid, fifo_count, overflow all 0 immediately; first event after release carries ts=0.
